// File: rtl/otter_mdu_if.sv
// otter_mdu_if: request/response bundle between the OTTER core and the MDU.
// The core drives START, FUNCT3, A and B. The MDU drives BUSY, DONE and RESULT.
interface otter_mdu_if;
    localparam int unsigned W = 32;

    logic         START;
    logic [2:0]   FUNCT3;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] RESULT;

    modport master (
        output START, FUNCT3, A, B,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FUNCT3, A, B,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/otter_mdu.sv
// otter_mdu: iterative RV32M multiply/divide unit.
// Each CALC cycle performs one radix-2 step.
// Divide-by-zero and signed overflow bypass CALC and go straight to FIN.
// Define MDU_DIV_EN to build the divide datapath. Without it, FUNCT3 4-7
// finish in two cycles and return zero.
module otter_mdu (
    input  logic       CLK,
    input  logic       RST,
    otter_mdu_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    state_t        state_q, state_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          a_neg, b_neg, res_neg;
    logic [W-1:0]  a_mag, b_mag;
    logic [W:0]    mul_sum;
    logic [W-1:0]  step_hi, step_lo;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]  fin_result;
`ifdef MDU_DIV_EN
    logic [W:0]    rem_sh;
    logic [W+1:0]  div_diff;
    logic          div_by_zero, div_ovf;
`endif

    // Operand conditioning: magnitudes of the signed operands and the result sign.
    always_comb begin
        a_neg = bus.A[W-1] & ((bus.FUNCT3 == F_MULH) | (bus.FUNCT3 == F_MULHSU) |
                              (bus.FUNCT3 == F_DIV)  | (bus.FUNCT3 == F_REM));
        b_neg = bus.B[W-1] & ((bus.FUNCT3 == F_MULH) | (bus.FUNCT3 == F_DIV) |
                              (bus.FUNCT3 == F_REM));
        a_mag = a_neg ? -bus.A : bus.A;
        b_mag = b_neg ? -bus.B : bus.B;
        // The remainder takes the dividend's sign. Every other result takes the XOR.
        res_neg = (bus.FUNCT3 == F_REM) ? a_neg : (a_neg ^ b_neg);
`ifdef MDU_DIV_EN
        div_by_zero = bus.FUNCT3[2] & (bus.B == '0);
        div_ovf     = (bus.FUNCT3 == F_DIV || bus.FUNCT3 == F_REM) &&
                      (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == '1);
`endif
    end

    // One radix-2 step.
    // Multiply: shift-add, multiplier in lo_q.
    // Divide: restoring shift-subtract, quotient in lo_q, remainder in hi_q.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        step_hi = mul_sum[W:1];
        step_lo = {mul_sum[0], lo_q[W-1:1]};
`ifdef MDU_DIV_EN
        rem_sh   = {hi_q, lo_q[W-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, b_q};
        if (funct3_q[2]) begin
            step_hi = div_diff[W+1] ? rem_sh[W-1:0] : div_diff[W-1:0];
            step_lo = {lo_q[W-2:0], ~div_diff[W+1]};
        end
`endif
    end

    // Sign correction and output field selection applied in FIN.
    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        if (funct3_q[2]) begin
`ifdef MDU_DIV_EN
            if (funct3_q[1]) fin_result = neg_q ? -hi_q : hi_q;
            else             fin_result = neg_q ? -lo_q : lo_q;
`else
            fin_result = '0;
`endif
        end else if (funct3_q == F_MUL) begin
            fin_result = prod_fix[W-1:0];
        end else begin
            fin_result = prod_fix[2*W-1:W];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    funct3_d = bus.FUNCT3;
                    hi_d     = '0;
                    lo_d     = a_mag;
                    b_d      = b_mag;
                    neg_d    = res_neg;
                    cnt_d    = '0;
                    state_d  = S_CALC;
`ifdef MDU_DIV_EN
                    // Special-case results are loaded directly into the quotient and remainder.
                    if (div_by_zero) begin
                        lo_d    = '1;
                        hi_d    = bus.A;
                        neg_d   = 1'b0;
                        state_d = S_FIN;
                    end else if (div_ovf) begin
                        lo_d    = {1'b1, {(W-1){1'b0}}};
                        hi_d    = '0;
                        neg_d   = 1'b0;
                        state_d = S_FIN;
                    end
`else
                    if (bus.FUNCT3[2]) begin
                        lo_d    = '0;
                        neg_d   = 1'b0;
                        state_d = S_FIN;
                    end
`endif
                end
            end
            S_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) state_d = S_FIN;
            end
            S_FIN: begin
                result_d = fin_result;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            funct3_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
endmodule
